debug_run_controller: RTL

Command-driven sequencer between the UART and the `Datapath`. It decodes single-byte commands from the UART receiver and performs one of three actions:
- start `LoadInstFSM` to load a program;
- run the pipeline until HALT;
- advance the pipeline one clock.

After every run or step it streams a state dump (cycle count, pipeline/register words, data-memory words) back through the UART transmitter.

---
 rtl/debug_run_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/debug_run_controller.sv
// Debug run controller: decodes UART commands to load, run or step the
// datapath, then streams cycle count, datapath words and memory words out.
module debug_run_controller #(
  parameter int PROC_BITS       = 32,
  parameter int DATA_ADDRS_BITS = 10,
  parameter int DUMP_WORDS      = 40,
  parameter int MEM_DUMP_WORDS  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_rx_done,
  input  logic [7:0]                 i_rx_data,
  output logic                       o_load_start,
  input  logic                       i_load_done,
  output logic                       o_dp_rst,
  output logic                       o_dp_enable,
  input  logic                       i_halt,
  output logic [5:0]                 o_word_sel,
  input  logic [PROC_BITS-1:0]       i_dump_word,
  output logic                       o_debug_read_data,
  output logic [DATA_ADDRS_BITS-1:0] o_debug_read_address,
  input  logic [PROC_BITS-1:0]       i_mem_data,
  output logic                       o_tx_start,
  output logic [7:0]                 o_tx_data,
  input  logic                       i_tx_done,
  output logic                       o_halted
);

  localparam int NBYTES = PROC_BITS / 8;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int NWORDS = 1 + DUMP_WORDS + MEM_DUMP_WORDS;
  localparam int IW     = $clog2(NWORDS + 1);

  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
  localparam logic [IW-1:0] LAST_WORD = IW'(NWORDS - 1);
  localparam logic [IW-1:0] LAST_DP   = IW'(DUMP_WORDS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_RST,
    S_RUN,
    S_STEP,
    S_SEL,
    S_MEMRD,
    S_BYTE,
    S_WAIT
  } state_t;

  state_t                     state_q;
  logic [31:0]                cnt_q;
  logic                       halted_q;
  logic                       load_start_q;
  logic                       dp_rst_q;
  logic                       dp_enable_q;
  logic [5:0]                 word_sel_q;
  logic                       rd_q;
  logic [DATA_ADDRS_BITS-1:0] addr_q;
  logic                       tx_start_q;
  logic [7:0]                 tx_data_q;
  logic [PROC_BITS-1:0]       shift_q;
  logic [IW-1:0]              word_idx_q;
  logic [BW-1:0]              byte_idx_q;
  logic [PROC_BITS-1:0]       word_d;

  // Source of the word being latched in S_SEL
  always_comb begin
    word_d = i_mem_data;
    if (word_idx_q == '0)
      word_d = PROC_BITS'(cnt_q);
    else if (word_idx_q <= LAST_DP)
      word_d = i_dump_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      halted_q     <= 1'b0;
      load_start_q <= 1'b0;
      dp_rst_q     <= 1'b1;
      dp_enable_q  <= 1'b0;
      word_sel_q   <= '0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      shift_q      <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
    end else begin
      load_start_q <= 1'b0;
      tx_start_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_rx_done) begin
            case (i_rx_data)
              8'h4C: begin
                state_q      <= S_LOAD;
                load_start_q <= 1'b1;
                dp_rst_q     <= 1'b0;
              end
              8'h52: begin
                word_idx_q <= '0;
                if (halted_q) begin
                  state_q <= S_SEL;
                end else begin
                  state_q     <= S_RUN;
                  dp_enable_q <= 1'b1;
                end
              end
              8'h53: begin
                word_idx_q <= '0;
                if (halted_q) begin
                  state_q <= S_SEL;
                end else begin
                  state_q     <= S_STEP;
                  dp_enable_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          if (i_load_done)
            state_q <= S_LOAD_RST;
        end
        S_LOAD_RST: begin
          cnt_q    <= '0;
          halted_q <= 1'b0;
          dp_rst_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        S_RUN: begin
          cnt_q <= cnt_q + 32'd1;
          if (i_halt) begin
            halted_q    <= 1'b1;
            dp_enable_q <= 1'b0;
            state_q     <= S_SEL;
          end
        end
        S_STEP: begin
          cnt_q       <= cnt_q + 32'd1;
          halted_q    <= halted_q | i_halt;
          dp_enable_q <= 1'b0;
          state_q     <= S_SEL;
        end
        S_SEL: begin
          tx_data_q  <= word_d[PROC_BITS-1 -: 8];
          shift_q    <= word_d << 8;
          tx_start_q <= 1'b1;
          byte_idx_q <= '0;
          state_q    <= S_BYTE;
        end
        S_MEMRD: begin
          state_q <= S_SEL;
        end
        S_BYTE: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (i_tx_done) begin
            if (byte_idx_q != LAST_BYTE) begin
              byte_idx_q <= byte_idx_q + 1'b1;
              tx_data_q  <= shift_q[PROC_BITS-1 -: 8];
              shift_q    <= shift_q << 8;
              tx_start_q <= 1'b1;
              state_q    <= S_BYTE;
            end else if (word_idx_q == LAST_WORD) begin
              rd_q    <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              word_idx_q <= word_idx_q + 1'b1;
              if (word_idx_q < LAST_DP) begin
                word_sel_q <= 6'(word_idx_q);
                state_q    <= S_SEL;
              end else begin
                // Memory data lags the address by a cycle
                rd_q    <= 1'b1;
                addr_q  <= DATA_ADDRS_BITS'(word_idx_q - LAST_DP);
                state_q <= S_MEMRD;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_load_start         = load_start_q;
  assign o_dp_rst             = dp_rst_q;
  assign o_dp_enable          = dp_enable_q;
  assign o_word_sel           = word_sel_q;
  assign o_debug_read_data    = rd_q;
  assign o_debug_read_address = addr_q;
  assign o_tx_start           = tx_start_q;
  assign o_tx_data            = tx_data_q;
  assign o_halted             = halted_q;

endmodule
